lsu_bus_ctrl: RTL

// - Load/store unit downstream of the decode controller. Consumes MemRead, MemWrite[1:0] and funct3, the ALU address and rs2 data.
// - Runs a multi-cycle req/gnt/rvalid transaction on the data-memory bus and stalls the core until it completes.
// - Returns sign/zero-extended load data for MemtoReg writeback.

---
 rtl/lsu_bus_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/lsu_bus_ctrl.sv
// Purpose : load/store unit driving a req/gnt/rvalid data-memory bus; stalls the core per access.
// Latency : 3 stall cycles minimum (IDLE, REQ+gnt, WAIT+rvalid); 2 when gnt and rvalid coincide.
// Backpr. : bus_req held until bus_gnt; WAIT aborts after TIMEOUT cycles with an err pulse.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   mem_read, mem_write   access request (mem_write!=0 is a store and wins over mem_read)
//   funct3, addr, wdata   load type, byte address, store data
//   stall                 combinational core hold
//   rdata, err            extended load data / error pulse, valid in DONE
//   bus_*                 data-memory bus (req/we/addr/be/wdata out, gnt/rvalid/rdata in)
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word accesses
// without touching the bus; otherwise such accesses are force-aligned.
module lsu_bus_ctrl #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic [1:0]  mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t          state, state_nxt;
    logic            access;
    logic            misalign;
    logic            timeout;
    logic            resp_now;
    logic [TO_W-1:0] cnt;
    logic [1:0]      k_l;
    logic [2:0]      f3_l;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_ext;

    assign access  = (mem_write != 2'b00) | mem_read;
    assign timeout = (state == WAIT) & (cnt == TO_W'(TIMEOUT - 1));
    // A response only counts when it completes the transaction from REQ or WAIT.
    assign resp_now = ((state == REQ) & bus_gnt & bus_rvalid) | ((state == WAIT) & bus_rvalid);

    always_comb begin
        misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (mem_write != 2'b00)
            misalign = ((mem_write == 2'b10) & addr[0]) |
                       ((mem_write == 2'b11) & (addr[1:0] != 2'b00));
        else
            misalign = (((funct3 == 3'b001) | (funct3 == 3'b101)) & addr[0]) |
                       ((funct3 == 3'b010) & (addr[1:0] != 2'b00));
`endif
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        bus_req   = 1'b0;
        case (state)
            IDLE: begin
                stall = access;
                if (access) state_nxt = misalign ? DONE : REQ;
            end
            REQ: begin
                stall   = 1'b1;
                bus_req = 1'b1;
                if (bus_gnt) state_nxt = bus_rvalid ? DONE : WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (bus_rvalid || timeout) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Load lane selection uses the byte offset captured when the access was accepted.
    always_comb begin
        case (k_l)
            2'd0:    ld_byte = bus_rdata[7:0];
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = k_l[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3_l)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_ext = bus_rdata;
            3'b100:  ld_ext = {24'b0, ld_byte};
            3'b101:  ld_ext = {16'b0, ld_half};
            default: ld_ext = 32'b0;
        endcase
        if (bus_we) ld_ext = 32'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus_we    <= 1'b0;
            bus_addr  <= 32'b0;
            bus_be    <= 4'b0;
            bus_wdata <= 32'b0;
            rdata     <= 32'b0;
            err       <= 1'b0;
            cnt       <= '0;
            k_l       <= 2'b0;
            f3_l      <= 3'b0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && access) begin
                bus_addr <= {addr[31:2], 2'b00};
                bus_we   <= (mem_write != 2'b00);
                k_l      <= addr[1:0];
                f3_l     <= funct3;
                case (mem_write)
                    2'b01: begin
                        bus_be    <= 4'b0001 << addr[1:0];
                        bus_wdata <= {4{wdata[7:0]}};
                    end
                    2'b10: begin
                        bus_be    <= 4'b0011 << {addr[1], 1'b0};
                        bus_wdata <= {2{wdata[15:0]}};
                    end
                    2'b11: begin
                        bus_be    <= 4'b1111;
                        bus_wdata <= wdata;
                    end
                    default: begin
                        bus_be    <= 4'b1111;
                        bus_wdata <= 32'b0;
                    end
                endcase
                if (misalign) begin
                    rdata <= 32'b0;
                    err   <= 1'b1;
                end
            end

            if (state == REQ && bus_gnt) cnt <= '0;
            if (state == WAIT)           cnt <= cnt + 1'b1;

            if (resp_now) begin
                rdata <= ld_ext;
                err   <= 1'b0;
            end else if (timeout) begin
                rdata <= 32'b0;
                err   <= 1'b1;
            end

            if (state == DONE) begin
                rdata <= 32'b0;
                err   <= 1'b0;
            end
        end
    end

endmodule
